// File: rtl/reg_arb_pkg.sv
// Shared types and constants for the two-master register-bus arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StAck   = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned RdLatW = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/reg_bus_arb2_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last goes.
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_id,
  output logic       gnt_vld
);

  always_comb begin
    gnt_vld = |req;
    gnt_id  = M0;
    unique case (req)
      2'b01:   gnt_id = M0;
      2'b10:   gnt_id = M1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = M0;
    endcase
  end

endmodule

// File: rtl/reg_bus_arb2.sv
// Round-robin sequencer sharing one register bus between m0 and m1.
// Define REG_ARB_STAT_EN to add saturating per-master ack counters m0_cnt/m1_cnt.
module reg_bus_arb2
  import reg_arb_pkg::*;
#(
  parameter int unsigned CPU_ADDR_WIDTH = 12,
  parameter int unsigned CPU_DATA_WIDTH = 32,
  parameter int unsigned RD_LAT         = 1
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] m0_addr,
  input  logic [CPU_DATA_WIDTH-1:0] m0_wdata,
  output logic                      m0_ack,
  output logic [CPU_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] m1_addr,
  input  logic [CPU_DATA_WIDTH-1:0] m1_wdata,
  output logic                      m1_ack,
  output logic [CPU_DATA_WIDTH-1:0] m1_rdata,
`ifdef REG_ARB_STAT_EN
  output logic [15:0]               m0_cnt,
  output logic [15:0]               m1_cnt,
`endif
  output logic                      cpu_wr,
  output logic                      cpu_rd,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out
);

  localparam logic [RdLatW-1:0] RdLatInit = RdLatW'(RD_LAT);
  localparam logic [RdLatW-1:0] CntOne    = RdLatW'(1);

  arb_state_e                state_q;
  logic                      last_gnt_q;
  logic                      id_q;
  logic                      wr_q;
  logic [RdLatW-1:0]         cnt_q;

  logic                      gnt_id;
  logic                      gnt_vld;
  logic                      sel_wr;
  logic [CPU_ADDR_WIDTH-1:0] sel_addr;
  logic [CPU_DATA_WIDTH-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt_q),
    .gnt_id   (gnt_id),
    .gnt_vld  (gnt_vld)
  );

  always_comb begin
    sel_wr    = m0_wr;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (gnt_id == M1) begin
      sel_wr    = m1_wr;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Bus fields are latched straight into the output registers when leaving IDLE.
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      last_gnt_q  <= M1;
      id_q        <= M0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_vld) begin
            id_q        <= gnt_id;
            wr_q        <= sel_wr;
            cpu_wr_addr <= sel_addr;
            cpu_data_in <= sel_wdata;
            cpu_wr      <= sel_wr;
            cpu_rd      <= ~sel_wr;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          cpu_wr <= 1'b0;
          cpu_rd <= 1'b0;
          if (wr_q) begin
            state_q <= StAck;
            if (id_q == M1) begin
              m1_ack   <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= '0;
            end
          end else begin
            cnt_q   <= RdLatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntOne;
          if (cnt_q == CntOne) begin
            state_q <= StAck;
            if (id_q == M1) begin
              m1_ack   <= 1'b1;
              m1_rdata <= cpu_data_out;
            end else begin
              m0_ack   <= 1'b1;
              m0_rdata <= cpu_data_out;
            end
          end
        end
        StAck: begin
          m0_ack     <= 1'b0;
          m1_ack     <= 1'b0;
          last_gnt_q <= id_q;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef REG_ARB_STAT_EN
  always_ff @(posedge clks or posedge reset) begin
    if (reset) begin
      m0_cnt <= '0;
      m1_cnt <= '0;
    end else if (state_q == StAck) begin
      if (id_q == M1) m1_cnt <= sat_inc16(m1_cnt);
      else            m0_cnt <= sat_inc16(m0_cnt);
    end
  end
`endif

endmodule
